// File: rtl/xilinx_fifo_sync_ctrl.sv
// Controller beside one xilinx_fifo_sync: reset/recovery sequencing, round-robin
// write-port sharing, gated reads with latency-aligned valid, sticky error flags.
//
// state         | meaning
// --------------+--------------------------------------------------------
// ST_RST_ASSERT | fifo_rst high for RST_CYCLES cycles
// ST_RECOVER    | fifo_rst low, enables/grants held off for RECOVER_CYCLES
// ST_RUN        | ready; writes arbitrated, reads gated by empty
module xilinx_fifo_sync_ctrl #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int RST_CYCLES     = 5,
  parameter int RECOVER_CYCLES = 4,
  parameter int READ_LATENCY   = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          init,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              gnt,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          ready,
  output logic [1:0]                    err,
  input  logic                          err_clr,
  output logic                          fifo_rst,
  output logic                          fifo_wren,
  output logic                          fifo_rden,
  output logic [DATA_WIDTH-1:0]         fifo_di,
  input  logic [DATA_WIDTH-1:0]         fifo_do,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic                          fifo_wrerr,
  input  logic                          fifo_rderr
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (RST_CYCLES > RECOVER_CYCLES) ? RST_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_TC = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_TC = CNT_W'(RECOVER_CYCLES - 1);

  localparam logic [1:0] ST_RST_ASSERT = 2'd0;
  localparam logic [1:0] ST_RECOVER    = 2'd1;
  localparam logic [1:0] ST_RUN        = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic                    run;
  logic [IDX_W-1:0]        last;
  logic [IDX_W-1:0]        sel;
  logic [IDX_W-1:0]        cand;
  logic                    found;
  logic                    gnt_ok;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [READ_LATENCY:0]   vld_ext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RST_ASSERT;
      cnt   <= '0;
    end else if (init) begin
      state <= ST_RST_ASSERT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RST_ASSERT: begin
          if (cnt == RST_TC) begin
            state <= ST_RECOVER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (cnt == REC_TC) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cnt <= '0;
        end
        default: begin
          state <= ST_RST_ASSERT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign run      = (state == ST_RUN);
  assign ready    = run;
  assign fifo_rst = (state == ST_RST_ASSERT);

  // Search starts one past the last winner so a steady requester set rotates.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign gnt_ok    = run && !fifo_full && found;
  assign gnt       = gnt_ok ? (N_REQ'(1) << sel) : '0;
  assign fifo_wren = gnt_ok;

  always_comb begin
    fifo_di = req_data[DATA_WIDTH-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_ok && sel == IDX_W'(i)) begin
        fifo_di = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= IDX_W'(N_REQ - 1);
    end else if (gnt_ok) begin
      last <= sel;
    end
  end

  assign fifo_rden = rd_req && !fifo_empty && run;
  assign vld_ext   = {vld_pipe, fifo_rden};
  assign rd_valid  = vld_pipe[READ_LATENCY-1];
  assign rd_data   = fifo_do;

  // init drops in-flight reads; the FIFO contents they refer to are being reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else if (init) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= vld_ext[READ_LATENCY-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 2'b00;
    end else begin
      err <= (err & {2{~err_clr}}) | ({fifo_rderr, fifo_wrerr} & {2{run}});
    end
  end

endmodule

// File: doc/xilinx_fifo_sync_ctrl.md
# xilinx_fifo_sync_ctrl

Controller for one `xilinx_fifo_sync` instance. It sequences the FIFO reset and recovery window that 7-series BRAM FIFOs require, and shares the single write port between `N_REQ` requesters with round-robin arbitration. It gates reads on the consumer side and delivers read data with a valid strobe aligned to the FIFO's read latency. It sits directly beside the FIFO and owns every FIFO control input.

## Interface
- `N_REQ`, 4: number of write requesters (2-16).
- `DATA_WIDTH`, 4: FIFO data width; must match the FIFO instance.
- `RST_CYCLES`, 5: cycles `FIFO_RST` is held high (≥5).
- `RECOVER_CYCLES`, 4: cycles after `FIFO_RST` falls during which `FIFO_WREN` and `FIFO_RDEN` stay low (≥2).
- `READ_LATENCY`, 1: `FIFO_RDEN`-to-`FIFO_DO` latency; 1 when `DO_REG`=0, 2 when `DO_REG`=1.

Ports:
- `CLK` in 1: single clock, shared with the FIFO.
- `RSTN` in 1: asynchronous, active-low reset.
- `INIT` in 1: synchronous pulse that restarts the reset sequence.
- `REQ` in `N_REQ`: per-requester write request.
- `REQ_DATA` in `N_REQ*DATA_WIDTH`: requester i's data sits at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `GNT` out `N_REQ`: one-hot grant, combinational; a word is written when `REQ[i]` & `GNT[i]`.
- `RD_REQ` in 1: consumer requests a pop.
- `RD_VALID` out 1: `RD_DATA` holds a popped word this cycle.
- `RD_DATA` out `DATA_WIDTH`: read data, passed through from `FIFO_DO`.
- `READY` out 1: controller is in RUN.
- `ERR` out 2: sticky error flags; [0] = write error, [1] = read error.
- `ERR_CLR` in 1: clears `ERR`.
- `FIFO_RST`, `FIFO_WREN`, `FIFO_RDEN` out 1: FIFO controls.
- `FIFO_DI` out `DATA_WIDTH`: FIFO write data.
- `FIFO_DO` in `DATA_WIDTH`: FIFO read data.
- `FIFO_FULL`, `FIFO_EMPTY`, `FIFO_WRERR`, `FIFO_RDERR` in 1: FIFO status.

## Operation
- The FSM has three states: RST_ASSERT, RECOVER and RUN.
  - `RSTN` low puts the FSM in RST_ASSERT with the counter at 0.
  - RST_ASSERT: `FIFO_RST`=1. After `RST_CYCLES` cycles with `RSTN` high, the FSM moves to RECOVER and the counter returns to 0.
  - RECOVER: `FIFO_RST`=0, with all enables and grants low. After `RECOVER_CYCLES` cycles, the FSM moves to RUN.
  - RUN: `READY`=1.
  - `INIT`=1 in any state moves the FSM to RST_ASSERT with the counter at 0. `INIT` overrides every other transition.
- Write arbitration (RUN only, `FIFO_FULL`=0):
  - Priority rotates, starting at index `last`+1 (mod `N_REQ`).
  - `GNT` is the first asserted `REQ` in that order.
  - `FIFO_WREN` = |`GNT`, and `FIFO_DI` = the granted requester's slice.
  - `last` updates to the granted index on the clock edge of the grant.
  - In any other state, or when `FIFO_FULL`=1, `GNT`=0 and `FIFO_WREN`=0.
  - `FIFO_DI` equals slice 0 when there is no grant.
- Read: `FIFO_RDEN` = `RD_REQ` & ~`FIFO_EMPTY` & `READY`.
  - A valid pipeline of depth `READ_LATENCY` carries each `FIFO_RDEN`. `RD_VALID` is the last stage.
  - `RD_DATA` = `FIFO_DO` (combinational).
  - Entering RST_ASSERT (through `RSTN` or `INIT`) flushes the valid pipeline to 0, so in-flight reads are discarded.
- Errors:
  - `ERR[0]` sets on `FIFO_WRERR` and `ERR[1]` sets on `FIFO_RDERR`, sampled only in RUN.
  - `ERR_CLR` clears both flags. If a flag sets and `ERR_CLR` is high in the same cycle, the set wins.
  - Neither error should ever occur under correct gating; the flags exist for assertion in the verification bench.

## Timing
- Reset values:
  - `FIFO_RST`=1.
  - `READY`=0, `RD_VALID`=0, `ERR`=0.
  - `GNT`=0, `FIFO_WREN`=0, `FIFO_RDEN`=0.
  - `last`=`N_REQ`-1, so requester 0 has the highest priority first.
- `RSTN` releases before edge 1:
  - `FIFO_RST` falls after edge `RST_CYCLES`.
  - `READY` rises after edge `RST_CYCLES`+`RECOVER_CYCLES` (9 with the defaults).
  - The first grant is possible in that same cycle.
- Write latency is 0: a grant and `FIFO_WREN` occur in the same cycle as `REQ`. `GNT` depends combinationally on `REQ`, `FIFO_FULL`, `last` and state.
- Read latency: `RD_VALID` rises exactly `READ_LATENCY` cycles after `FIFO_RDEN`. Back-to-back reads give back-to-back `RD_VALID`.
- `FIFO_FULL` and `FIFO_EMPTY` are used combinationally. The FIFO updates them on the edge after the write or read, which prevents overflow and underflow at 0 extra cost.
- Requester grant is at most one per cycle. A continuously requesting set of k requesters is served in strict rotation, each once every k cycles.

## Test plan
- Reset sequence, defaults: release `RSTN` → `FIFO_RST` high for 5 cycles; then 4 cycles with `FIFO_WREN`/`FIFO_RDEN`=0; `READY`=1 on cycle 9.
- Round-robin: `REQ`=4'b1111 for 8 cycles in RUN → `GNT` sequence 1, 2, 4, 8, 1, 2, 4, 8. With only `REQ`=4'b1010, grants alternate 2, 8.
- Full back-pressure: 18Kb FIFO with `DATA_WIDTH` 4 (depth 4096); fill until `FIFO_FULL`=1 → `GNT`=0 while full; `ERR[0]` stays 0; write resumes on the cycle after the first pop clears `FULL`.
- Read latency: `READ_LATENCY`=2; write 0x3, 0x5; hold `RD_REQ` → `RD_VALID` high 2 and 3 cycles after the first `FIFO_RDEN` with `RD_DATA` 0x3 then 0x5; `FIFO_RDEN` is never high while `EMPTY`.
- `INIT` mid-operation: pulse `INIT` during a read burst with a read in flight → `RD_VALID` drops next cycle; `READY`=0; `FIFO_RST` high 5 cycles; `READY` returns 9 cycles later.
- Error stickiness: force `FIFO_RDERR` for 1 cycle in RUN → `ERR`=2'b10 until `ERR_CLR`. With `ERR_CLR` and `FIFO_WRERR` in the same cycle → `ERR[0]`=1.
